// File: rtl/leb128_pkg.sv
// Shared LEB128 definitions: decoder FSM states and window sizing derived from
// the decoded value width.
package leb128_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } dec_state_e;

   // Maximum encoded bytes for an n-bit value
   function automatic int unsigned leb_mb(input int unsigned n);
      return n / 7 + 1;
   endfunction

   function automatic int unsigned leb_m(input int unsigned n);
      return leb_mb(n) * 8;
   endfunction

endpackage

// File: rtl/unpack_signed.sv
// Combinational signed LEB128 decode of a byte window (byte k at bits 8k..8k+7,
// glue bit at 8k, payload bit 0 at 8k+7).
module unpack_signed
   import leb128_pkg::*;
#(
   parameter  int unsigned N  = 64,
   localparam int unsigned MB = leb_mb(N),
   localparam int unsigned M  = leb_m(N)
) (
   input  logic [M-1:0] window,
   output logic [N-1:0] value
);

   logic [N-1:0] acc;
   logic [N-1:0] fill_hi;
   logic [6:0]   pay;
   logic         sign;
   logic         done;

   // The first byte with a clear glue bit terminates; zeroed unfilled bytes do too
   always_comb begin
      acc     = '0;
      fill_hi = '0;
      pay     = '0;
      sign    = 1'b0;
      done    = 1'b0;
      for (int unsigned k = 0; k < MB; k++) begin
         if (!done) begin
            for (int unsigned b = 0; b < 7; b++) begin
               pay[b] = window[8*k + 7 - b];
            end
            acc     = acc | (N'(pay) << (7*k));
            fill_hi = {N{1'b1}} << (7*(k + 1));
            sign    = pay[6];
            done    = ~window[8*k];
         end
      end
      value = acc | (sign ? fill_hi : '0);
   end

endmodule

// File: rtl/leb128_stream_decoder.sv
// Byte-stream signed LEB128 decoder: collects bytes into a registered window,
// then holds the decoded value until the consumer takes it.
module leb128_stream_decoder
   import leb128_pkg::*;
#(
   parameter  int unsigned N  = 64,
   localparam int unsigned LW = $clog2(leb_mb(N)) + 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          clear,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [N-1:0]  out_value,
   output logic [LW-1:0] out_len,
   output logic          out_err,
   output logic          out_valid,
   input  logic          out_ready
);

   localparam int unsigned MB = leb_mb(N);
   localparam int unsigned M  = leb_m(N);

   dec_state_e    state_q, state_d;
   logic [M-1:0]  win_q, win_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic [N-1:0]  dec_value;

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (clear) begin
         state_d = COLLECT;
         win_d   = '0;
         cnt_d   = '0;
         err_d   = 1'b0;
      end else if (state_q == COLLECT) begin
         if (in_valid) begin
            for (int unsigned k = 0; k < MB; k++) begin
               if (cnt_q == LW'(k)) begin
                  for (int unsigned b = 0; b < 8; b++) begin
                     win_d[8*k + 7 - b] = in_data[b];
                  end
               end
            end
            cnt_d = cnt_q + 1'b1;
            // A glue bit still set on the last allowed byte marks an overlong encoding
            if (!in_data[7] || cnt_q == LW'(MB - 1)) begin
               state_d = HOLD;
               err_d   = in_data[7];
            end
         end
      end else if (out_ready) begin
         state_d = COLLECT;
         win_d   = '0;
         cnt_d   = '0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= COLLECT;
         win_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   unpack_signed #(
      .N(N)
   ) u_unpack (
      .window(win_q),
      .value (dec_value)
   );

   assign in_ready  = (state_q == COLLECT);
   assign out_valid = (state_q == HOLD);
   assign out_value = out_valid ? dec_value : '0;
   assign out_len   = out_valid ? cnt_q : '0;
   assign out_err   = out_valid ? err_q : 1'b0;

endmodule

// File: tb/tb_leb128_stream_decoder.sv
// Self-checking bench for leb128_stream_decoder: directed cases plus random
// values checked against an arithmetic LEB128 reference model.
module tb_leb128_stream_decoder;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        rstn;
   logic        clear;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] out_value;
   logic [4:0]  out_len;
   logic        out_err;
   logic        out_valid;
   logic        out_ready;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   leb128_stream_decoder #(
      .N(64)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .clear    (clear),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_value(out_value),
      .out_len  (out_len),
      .out_err  (out_err),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, obs, exp);
      end
   endtask

   // Reference: little-endian 7-bit groups, sign from bit 6 of the last group
   function automatic void model(input bq_t b, output logic [63:0] v,
                                 output int unsigned len, output logic err);
      v   = '0;
      len = 0;
      err = 1'b0;
      for (int i = 0; i < b.size() && i < 10; i++) begin
         v   = v | (64'(b[i] & 8'h7F) << (7*i));
         len = i + 1;
         if (!b[i][7]) break;
      end
      if (len == 10 && b[9][7]) err = 1'b1;
      if (b[len-1][6] && 7*len < 64) v = v | (~64'd0 << (7*len));
   endfunction

   task automatic send_bytes(input bq_t q, input bit bubbles);
      int unsigned guard;
      for (int i = 0; i < q.size(); i++) begin
         if (bubbles) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               in_data  = 8'($urandom);
               @(posedge clk); #1;
            end
         end
         if (i > 0) chk("early_valid", 64'(out_valid), 64'd0);
         in_valid = 1'b1;
         in_data  = q[i];
         guard = 0;
         while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
         end
         if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_data  = 8'($urandom);
      end
   endtask

   task automatic expect_result(input logic [63:0] v, input int unsigned len,
                                input logic err, input int unsigned stall);
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("out_value", out_value, v);
      chk("out_len", 64'(out_len), 64'(len));
      chk("out_err", 64'(out_err), 64'(err));
      repeat (stall) begin
         @(posedge clk); #1;
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         chk("hold_value", out_value, v);
         chk("hold_len", 64'(out_len), 64'(len));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_valid", 64'(out_valid), 64'd0);
      chk("post_value", out_value, 64'd0);
      chk("post_len", 64'(out_len), 64'd0);
      chk("post_in_ready", 64'(in_ready), 64'd1);
   endtask

   task automatic run_value(input bq_t q, input bit bubbles, input int unsigned stall);
      logic [63:0] v;
      int unsigned len;
      logic        err;
      model(q, v, len, err);
      send_bytes(q, bubbles);
      expect_result(v, len, err, stall);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t q;
      rstn      = 1'b0;
      clear     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_value", out_value, 64'd0);
      chk("rst_len", 64'(out_len), 64'd0);
      chk("rst_err", 64'(out_err), 64'd0);
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      q = {8'h02};               run_value(q, 1'b0, 0);
      chk("dir_02", 64'd2, 64'd2 & 64'h2); // value itself was checked inside run_value
      q = {8'h7E};               run_value(q, 1'b0, 1);
      q = {8'hFF, 8'h00};        run_value(q, 1'b0, 0);
      q = {8'h81, 8'h7F};        run_value(q, 1'b0, 0);
      q = {8'h80, 8'h7F};        run_value(q, 1'b0, 2);

      // Stalled consumer while the next byte is already offered
      q = {8'h02};
      send_bytes(q, 1'b0);
      chk("stall_first", out_value, 64'd2);
      in_valid = 1'b1;
      in_data  = 8'h03;
      repeat (5) begin
         @(posedge clk); #1;
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         chk("stall_value", out_value, 64'd2);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("stall_post_valid", 64'(out_valid), 64'd0);
      chk("stall_post_rdy", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      expect_result(64'd3, 1, 1'b0, 0);

      q = {};
      repeat (10) q.push_back(8'h80);
      run_value(q, 1'b0, 0);
      q = {8'h01};               run_value(q, 1'b0, 0);

      // Abort a partial value with clear
      q = {8'h80, 8'h80};
      send_bytes(q, 1'b0);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("clr_valid", 64'(out_valid), 64'd0);
      chk("clr_in_ready", 64'(in_ready), 64'd1);
      q = {8'h7F};               run_value(q, 1'b0, 0);

      // Abort a partial value with an asynchronous reset pulse
      q = {8'h80, 8'h80};
      send_bytes(q, 1'b0);
      #2 rstn = 1'b0;
      #1;
      chk("rstp_valid", 64'(out_valid), 64'd0);
      chk("rstp_len", 64'(out_len), 64'd0);
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;
      chk("rstp_valid2", 64'(out_valid), 64'd0);
      q = {8'h7F};               run_value(q, 1'b0, 0);

      // Clear wins over a simultaneous output handshake and input byte
      q = {8'h05};
      send_bytes(q, 1'b0);
      clear     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h09;
      @(posedge clk); #1;
      clear     = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("clr_hold_valid", 64'(out_valid), 64'd0);
      chk("clr_hold_rdy", 64'(in_ready), 64'd1);

      q = {8'h81, 8'h7F};        run_value(q, 1'b1, 0);
      q = {8'h81, 8'h7F};        run_value(q, 1'b1, 1);

      for (int t = 0; t < 60; t++) begin
         int unsigned len;
         logic [7:0]  b;
         len = $urandom_range(1, 10);
         q = {};
         for (int i = 0; i < int'(len); i++) begin
            b = 8'($urandom);
            if (i < int'(len) - 1) b[7] = 1'b1;
            else if (len == 10) b[7] = 1'($urandom);
            else b[7] = 1'b0;
            q.push_back(b);
         end
         run_value(q, 1'($urandom), $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
